iot_filter_ctrl: RTL and testbench

IOT_FILTER_CTRL -- requirements
Module: iot_filter_ctrl

---
 rtl/iot_filter_ctrl.sv | 138 +++++++++++++
 tb/tb_iot_filter_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iot_filter_ctrl.sv
// Filter-round controller: assembles an MSB-first byte stream into 128-bit words,
// runs a number of rounds, and hands each round's datapath result out over valid/ready.
module iot_filter_ctrl #(
    parameter int BYTES_PER_WORD  = 16,
    parameter int WORDS_PER_ROUND = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [2:0]                  fn_sel_in,
    input  logic [7:0]                  num_rounds,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [7:0]                  iot_in,
    output logic [2:0]                  fn_sel,
    output logic [8*BYTES_PER_WORD-1:0] data,
    output logic [5:0]                  cnt,
    output logic [2:0]                  state,
    output logic                        flag,
    output logic [7:0]                  cycle_cnt,
    input  logic [8*BYTES_PER_WORD-1:0] res_in,
    input  logic                        res_en,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [8*BYTES_PER_WORD-1:0] out_data,
    output logic                        busy,
    output logic                        done
);

    localparam int WORD_W = 8 * BYTES_PER_WORD;
    localparam int BC_W   = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_LOAD = 3'b001,
        S_EVAL = 3'b010,
        S_OUT  = 3'b011,
        S_DONE = 3'b100
    } state_t;

    state_t            cur, nxt;
    logic [BC_W-1:0]   byte_cnt;
    logic [WORD_W-1:0] asm_q;
    logic [WORD_W-1:0] asm_next;
    logic [7:0]        rounds_eff;
    logic              accept, take_byte, word_done, capture, round_end, last_round;

    // Both handshakes transfer on a rising edge where valid and ready are both 1;
    // the producer holds its payload and valid steady until that edge.
    assign in_ready  = (cur == S_LOAD);
    assign out_valid = (cur == S_OUT);
    assign busy      = (cur != S_IDLE);
    assign done      = (cur == S_DONE);
    assign state     = cur;
    assign asm_next  = {asm_q[WORD_W-9:0], iot_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur <= S_IDLE;
        else     cur <= nxt;
    end

    always_comb begin
        nxt        = cur;
        accept     = 1'b0;
        take_byte  = 1'b0;
        word_done  = 1'b0;
        capture    = 1'b0;
        round_end  = 1'b0;
        last_round = (({1'b0, cycle_cnt} + 9'd1) == {1'b0, rounds_eff});
        case (cur)
            S_IDLE: begin
                accept = start;
                if (start) nxt = S_LOAD;
            end
            S_LOAD: begin
                take_byte = in_valid;
                word_done = in_valid && (byte_cnt == BC_W'(BYTES_PER_WORD - 1));
                if (word_done && (cnt == 6'(WORDS_PER_ROUND - 1))) nxt = S_EVAL;
            end
            S_EVAL: begin
                if (!flag || res_en) begin
                    capture = 1'b1;
                    nxt     = S_OUT;
                end else begin
                    round_end = 1'b1;
                    nxt       = last_round ? S_DONE : S_LOAD;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    round_end = 1'b1;
                    nxt       = last_round ? S_DONE : S_LOAD;
                end
            end
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fn_sel     <= '0;
            rounds_eff <= '0;
            cycle_cnt  <= '0;
            flag       <= 1'b0;
            cnt        <= '0;
            byte_cnt   <= '0;
            asm_q      <= '0;
            data       <= '0;
            out_data   <= '0;
        end else begin
            if (accept) begin
                fn_sel     <= fn_sel_in;
                rounds_eff <= (num_rounds == 8'd0) ? 8'd1 : num_rounds;
                cycle_cnt  <= '0;
                flag       <= 1'b0;
                cnt        <= '0;
                byte_cnt   <= '0;
            end
            if (take_byte) begin
                asm_q    <= asm_next;
                byte_cnt <= word_done ? '0 : byte_cnt + 1'b1;
            end
            if (word_done) begin
                data <= asm_next;
                cnt  <= cnt + 6'd1;
            end
            if (capture) out_data <= res_in;
            // The final round leaves cycle_cnt at its index so it never wraps.
            if (round_end) begin
                cnt  <= '0;
                flag <= 1'b1;
                if (!last_round) cycle_cnt <= cycle_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_iot_filter_ctrl.sv
// Randomized bench for iot_filter_ctrl: drives whole operations and compares the
// observed words, outputs and round bookkeeping with a queue-based round model.
module tb_iot_filter_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   fn_sel_in;
    logic [7:0]   num_rounds;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   iot_in;
    logic [2:0]   fn_sel;
    logic [127:0] data;
    logic [5:0]   cnt;
    logic [2:0]   state;
    logic         flag;
    logic [7:0]   cycle_cnt;
    logic [127:0] res_in;
    logic         res_en;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
    logic         done;

    iot_filter_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .fn_sel_in(fn_sel_in), .num_rounds(num_rounds),
        .in_valid(in_valid), .in_ready(in_ready), .iot_in(iot_in), .fn_sel(fn_sel),
        .data(data), .cnt(cnt), .state(state), .flag(flag), .cycle_cnt(cycle_cnt),
        .res_in(res_in), .res_en(res_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [127:0] exp_q[$];
    logic [127:0] exp_words[$];
    logic [127:0] obs_words[$];
    logic [127:0] obs_out[$];
    int           obs_cnts[$];
    logic         obs_flag[$];
    bit           round_en[256];
    logic [127:0] round_res[256];

    int total = 0;
    int bad   = 0;
    int eval_cycles, done_pulses, cc_at_done, timeout;
    int first_byte_cyc, last_byte_cyc, first_eval_cyc;
    int stall_unstable, stall_cycles, stall_inready, stall_cnt_bad;
    logic [2:0] fn_at_done, state_after;
    logic       busy_after;

    // One whole operation; records what the DUT did, and builds the model's expectations.
    task automatic run_op(input logic [2:0] fn, input logic [7:0] nr, input int valid_pct,
                          input int stall, input bit seq, input bit glitch);
        int rounds_eff, nbytes, cyc, stall_left, prev_cnt, ridx, budget;
        logic [127:0] w, ref_od;
        bit done_seen, glitched;
        rounds_eff = (nr == 8'd0) ? 1 : int'(nr);
        exp_q.delete(); exp_words.delete(); obs_words.delete();
        obs_out.delete(); obs_cnts.delete(); obs_flag.delete();
        eval_cycles = 0; done_pulses = 0; cc_at_done = -1; timeout = 0;
        first_byte_cyc = -1; last_byte_cyc = -1; first_eval_cyc = -1;
        stall_unstable = 0; stall_cycles = 0; stall_inready = 0; stall_cnt_bad = 0;
        fn_at_done = 3'bx; ref_od = '0; w = '0;
        for (int r = 0; r < rounds_eff; r++) begin
            round_res[r] = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (r == 0 || round_en[r]) exp_q.push_back(round_res[r]);
        end
        @(negedge clk);
        start = 1'b1; fn_sel_in = fn; num_rounds = nr;
        @(negedge clk);
        nbytes = 0; cyc = 0; prev_cnt = 0; done_seen = 0; glitched = 0; stall_left = stall;
        budget = rounds_eff * 1200 + 200;
        while (!done_seen && cyc < budget) begin
            if (int'(cnt) != prev_cnt && cnt != 6'd0) begin
                obs_cnts.push_back(int'(cnt));
                obs_words.push_back(data);
            end
            prev_cnt = int'(cnt);
            if (state == 3'b010) begin
                eval_cycles++;
                obs_flag.push_back(flag);
                if (first_eval_cyc < 0) first_eval_cyc = cyc;
            end
            if (done) begin
                done_pulses++; cc_at_done = int'(cycle_cnt); fn_at_done = fn_sel; done_seen = 1;
            end
            start = 1'b0; fn_sel_in = 3'($urandom); num_rounds = 8'($urandom);
            if (glitch && !glitched && state == 3'b001 && nbytes >= 40) begin
                start = 1'b1; fn_sel_in = 3'd3; num_rounds = 8'd1; glitched = 1;
            end
            in_valid = ($urandom_range(99) < valid_pct);
            iot_in   = seq ? 8'(nbytes) : 8'($urandom);
            if (stall_left > 0 && (out_valid || stall_left < stall)) begin
                if (stall_left == stall) ref_od = out_data;
                else if (out_data !== ref_od || out_valid !== 1'b1) stall_unstable++;
                out_ready = 1'b0; in_valid = 1'b1; stall_cycles++;
                if (in_ready) stall_inready++;
                if (cnt != 6'd16) stall_cnt_bad++;
                stall_left--;
            end else begin
                out_ready = 1'($urandom);
            end
            if (in_valid && in_ready) begin
                w = {w[119:0], iot_in};
                nbytes++;
                if (first_byte_cyc < 0) first_byte_cyc = cyc;
                if (nbytes == 256) last_byte_cyc = cyc;
                if (nbytes % 16 == 0) exp_words.push_back(w);
            end
            if (out_valid && out_ready) obs_out.push_back(out_data);
            ridx = (nbytes < 16) ? 0 : ((nbytes / 16) - 1) / 16;
            if (ridx > 255) ridx = 255;
            res_in = round_res[ridx]; res_en = round_en[ridx];
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        if (!done_seen) timeout = 1;
        state_after = state; busy_after = busy;
        repeat (3) begin
            if (done) done_pulses++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (state !== 3'b000) begin bad++; $display("FAIL rst_state got=%0h want=0", state); end
        total++; if (cnt !== 6'd0 || cycle_cnt !== 8'd0 || flag !== 1'b0 || fn_sel !== 3'd0) begin
            bad++; $display("FAIL rst_counters got cnt=%0d cc=%0d flag=%0b fn=%0d want all 0", cnt, cycle_cnt, flag, fn_sel); end
        total++; if (data !== 128'd0 || out_data !== 128'd0) begin
            bad++; $display("FAIL rst_data got data=%0h out=%0h want 0", data, out_data); end
        total++; if ({out_valid, in_ready, busy, done} !== 4'b0000) begin
            bad++; $display("FAIL rst_flags got=%b want=0000", {out_valid, in_ready, busy, done}); end
        rst = 1'b0;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (in_ready !== 1'b0 || state !== 3'b000) begin
            bad++; $display("FAIL idle_no_start got in_ready=%0b state=%0h want 0/0", in_ready, state); end
        in_valid = 1'b0;
    endtask

    task automatic test_single_round();
        round_en[0] = 1'b0;
        run_op(3'd7, 8'd1, 100, 0, 1'b1, 1'b0);
        total++; if (timeout != 0) begin bad++; $display("FAIL single_timeout got=%0d want=0", timeout); end
        total++; if (obs_cnts.size() != 16) begin bad++; $display("FAIL single_cnt_steps got=%0d want=16", obs_cnts.size()); end
        for (int i = 0; i < obs_cnts.size(); i++) begin
            total++; if (obs_cnts[i] != i + 1) begin bad++; $display("FAIL single_cnt[%0d] got=%0d want=%0d", i, obs_cnts[i], i + 1); end
        end
        total++; if (obs_words.size() == 0 || obs_words[0] !== 128'h000102030405060708090a0b0c0d0e0f) begin
            bad++; $display("FAIL single_first_word got=%0h want=000102030405060708090a0b0c0d0e0f", obs_words.size() ? obs_words[0] : 128'bx); end
        total++; if (obs_words.size() != exp_words.size()) begin
            bad++; $display("FAIL single_words_n got=%0d want=%0d", obs_words.size(), exp_words.size()); end
        for (int i = 0; i < obs_words.size() && i < exp_words.size(); i++) begin
            total++; if (obs_words[i] !== exp_words[i]) begin bad++; $display("FAIL single_word[%0d] got=%0h want=%0h", i, obs_words[i], exp_words[i]); end
        end
        total++; if (last_byte_cyc - first_byte_cyc != 255) begin
            bad++; $display("FAIL single_no_bubble got=%0d want=255", last_byte_cyc - first_byte_cyc); end
        total++; if (first_eval_cyc != last_byte_cyc + 1 || eval_cycles != 1) begin
            bad++; $display("FAIL single_eval got at=%0d n=%0d want at=%0d n=1", first_eval_cyc, eval_cycles, last_byte_cyc + 1); end
        total++; if (obs_out.size() != 1 || obs_out[0] !== exp_q[0]) begin
            bad++; $display("FAIL single_out got n=%0d want n=1 val=%0h", obs_out.size(), exp_q[0]); end
        total++; if (done_pulses != 1 || fn_at_done !== 3'd7) begin
            bad++; $display("FAIL single_done got pulses=%0d fn=%0d want 1/7", done_pulses, fn_at_done); end
        total++; if (state_after !== 3'b000 || busy_after !== 1'b0) begin
            bad++; $display("FAIL single_idle got state=%0h busy=%0b want 0/0", state_after, busy_after); end
    endtask

    task automatic test_skip_rounds();
        round_en[0] = 1'b0; round_en[1] = 1'b0; round_en[2] = 1'b0;
        run_op(3'd1, 8'd3, 70, 0, 1'b0, 1'b0);
        total++; if (timeout != 0 || eval_cycles != 3) begin
            bad++; $display("FAIL skip_rounds got timeout=%0d evals=%0d want 0/3", timeout, eval_cycles); end
        total++; if (obs_out.size() != 1 || obs_out[0] !== exp_q[0]) begin
            bad++; $display("FAIL skip_out got n=%0d want n=1 val=%0h", obs_out.size(), exp_q[0]); end
        for (int i = 0; i < obs_flag.size(); i++) begin
            total++; if (obs_flag[i] !== (i > 0)) begin bad++; $display("FAIL skip_flag[%0d] got=%0b want=%0b", i, obs_flag[i], i > 0); end
        end
        total++; if (cc_at_done != 2 || done_pulses != 1) begin
            bad++; $display("FAIL skip_done got cc=%0d pulses=%0d want 2/1", cc_at_done, done_pulses); end
        total++; if (obs_words.size() != 48 || exp_words.size() != 48 || obs_words[47] !== exp_words[47]) begin
            bad++; $display("FAIL skip_words got n=%0d want 48 matching", obs_words.size()); end
    endtask

    task automatic test_out_stall();
        round_en[0] = 1'b1; round_en[1] = 1'b1;
        run_op(3'd4, 8'd2, 80, 5, 1'b0, 1'b0);
        total++; if (stall_cycles != 5 || stall_unstable != 0) begin
            bad++; $display("FAIL stall_stable got cycles=%0d unstable=%0d want 5/0", stall_cycles, stall_unstable); end
        total++; if (stall_inready != 0 || stall_cnt_bad != 0) begin
            bad++; $display("FAIL stall_no_consume got in_ready=%0d cnt_bad=%0d want 0/0", stall_inready, stall_cnt_bad); end
        total++; if (obs_out.size() != exp_q.size()) begin
            bad++; $display("FAIL stall_out_n got=%0d want=%0d", obs_out.size(), exp_q.size()); end
        for (int i = 0; i < obs_out.size() && i < exp_q.size(); i++) begin
            total++; if (obs_out[i] !== exp_q[i]) begin bad++; $display("FAIL stall_out[%0d] got=%0h want=%0h", i, obs_out[i], exp_q[i]); end
        end
        total++; if (cc_at_done != 1 || timeout != 0) begin
            bad++; $display("FAIL stall_done got cc=%0d timeout=%0d want 1/0", cc_at_done, timeout); end
    endtask

    task automatic test_zero_rounds();
        round_en[0] = 1'b1;
        run_op(3'd2, 8'd0, 90, 0, 1'b0, 1'b0);
        total++; if (eval_cycles != 1 || cc_at_done != 0 || done_pulses != 1) begin
            bad++; $display("FAIL zero_rounds got evals=%0d cc=%0d pulses=%0d want 1/0/1", eval_cycles, cc_at_done, done_pulses); end
        total++; if (obs_out.size() != 1 || obs_out[0] !== exp_q[0]) begin
            bad++; $display("FAIL zero_out got n=%0d want n=1 val=%0h", obs_out.size(), exp_q[0]); end
    endtask

    task automatic test_start_in_load();
        round_en[0] = 1'b0; round_en[1] = 1'b1;
        run_op(3'd5, 8'd2, 75, 0, 1'b0, 1'b1);
        total++; if (fn_at_done !== 3'd5) begin bad++; $display("FAIL glitch_fn got=%0d want=5", fn_at_done); end
        total++; if (eval_cycles != 2 || cc_at_done != 1) begin
            bad++; $display("FAIL glitch_rounds got evals=%0d cc=%0d want 2/1", eval_cycles, cc_at_done); end
        total++; if (obs_out.size() != 2 || obs_out[0] !== exp_q[0] || obs_out[1] !== exp_q[1]) begin
            bad++; $display("FAIL glitch_out got n=%0d want 2 matching", obs_out.size()); end
    endtask

    task automatic test_random_rounds();
        for (int r = 0; r < 4; r++) round_en[r] = 1'($urandom);
        run_op(3'($urandom), 8'd4, 55, 0, 1'b0, 1'b0);
        total++; if (eval_cycles != 4 || cc_at_done != 3 || timeout != 0) begin
            bad++; $display("FAIL rand_rounds got evals=%0d cc=%0d timeout=%0d want 4/3/0", eval_cycles, cc_at_done, timeout); end
        total++; if (obs_out.size() != exp_q.size()) begin
            bad++; $display("FAIL rand_out_n got=%0d want=%0d", obs_out.size(), exp_q.size()); end
        for (int i = 0; i < obs_out.size() && i < exp_q.size(); i++) begin
            total++; if (obs_out[i] !== exp_q[i]) begin bad++; $display("FAIL rand_out[%0d] got=%0h want=%0h", i, obs_out[i], exp_q[i]); end
        end
        for (int i = 0; i < obs_words.size() && i < exp_words.size(); i++) begin
            total++; if (obs_words[i] !== exp_words[i]) begin bad++; $display("FAIL rand_word[%0d] got=%0h want=%0h", i, obs_words[i], exp_words[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int nbytes, cyc, stuck;
        @(negedge clk);
        start = 1'b1; fn_sel_in = 3'd6; num_rounds = 8'd1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; nbytes = 0; cyc = 0; stuck = 0;
        while (nbytes < 152 && cyc < 400) begin
            iot_in = 8'($urandom);
            if (in_ready) nbytes++;
            if (nbytes < 152) begin @(negedge clk); cyc++; end
        end
        total++; if (nbytes != 152) begin bad++; $display("FAIL mid_stream got bytes=%0d want=152", nbytes); end
        @(posedge clk);
        #2;
        total++; if (cnt !== 6'd9) begin bad++; $display("FAIL mid_pre_cnt got=%0d want=9", cnt); end
        rst = 1'b1;
        #1;
        total++; if (state !== 3'b000 || cnt !== 6'd0 || cycle_cnt !== 8'd0 || flag !== 1'b0 || fn_sel !== 3'd0) begin
            bad++; $display("FAIL mid_rst_regs got st=%0h cnt=%0d cc=%0d flag=%0b fn=%0d want 0", state, cnt, cycle_cnt, flag, fn_sel); end
        total++; if (data !== 128'd0 || out_data !== 128'd0 || {out_valid, in_ready, busy, done} !== 4'b0000) begin
            bad++; $display("FAIL mid_rst_outs got data=%0h out=%0h flags=%b want 0", data, out_data, {out_valid, in_ready, busy, done}); end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || state !== 3'b000 || cnt !== 6'd0) stuck++;
        end
        total++; if (stuck != 0) begin bad++; $display("FAIL mid_no_restart got=%0d want=0", stuck); end
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; fn_sel_in = '0; num_rounds = '0; in_valid = 1'b0;
        iot_in = '0; res_in = '0; res_en = 1'b0; out_ready = 1'b0;
        test_reset();
        test_single_round();
        test_skip_rounds();
        test_out_stall();
        test_zero_rounds();
        test_start_in_load();
        test_random_rounds();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
